mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Arbitrates one shared single-port memory bus between the IF stage (requester 0) and the MEM stage (requester 1).
//  Sequences each transaction: grant, hold, complete on ack, or abort on timeout.
//  Drives the select of the shared 2-to-1 address/write-data mux: 0 = IF, 1 = MEM.
//  MEM has priority; a starvation counter guarantees IF forward progress.
// PARAMETERS
//  MAX_STARVE  2   IF arbitration losses tolerated before IF wins a contended decision (>=1)
//  TIMEOUT     16  max cycles a grant waits for bus_ack before abort (>=2)
// PORTS
//  CLK       in   1  clock, rising edge
//  RST       in   1  synchronous reset, active-high
//  if_req    in   1  IF requests bus; held until if_done or arb_err
//  mem_req   in   1  MEM requests bus; held until mem_done or arb_err
//  mem_we    in   1  MEM write strobe; sampled with grant
//  bus_ack   in   1  memory completes current transaction
//  if_gnt    out  1  IF owns bus (registered)
//  mem_gnt   out  1  MEM owns bus (registered)
//  if_done   out  1  IF transaction complete (1-cycle pulse)
//  mem_done  out  1  MEM transaction complete (1-cycle pulse)
//  mux_sel   out  1  shared mux select, 0=IF 1=MEM (registered)
//  bus_req   out  1  request to memory (registered)
//  bus_we    out  1  write to memory; latched mem_we for MEM grant, 0 for IF
//  arb_err   out  1  timeout abort (1-cycle pulse)
// BEHAVIOUR
//  States: IDLE, GNT_IF, GNT_MEM.
//  Reset: state IDLE; all outputs 0; mux_sel 0; starve_cnt 0; to_cnt 0.
//  IDLE decision (cycle N), registered, effective at N+1:
//   - only if_req -> GNT_IF
//   - only mem_req -> GNT_MEM
//   - both, starve_cnt==MAX_STARVE -> GNT_IF
//   - both, otherwise -> GNT_MEM; starve_cnt++ (saturates at MAX_STARVE)
//   - none -> stay IDLE
//   - starve_cnt clears on every entry to GNT_IF
//  GNT_x outputs (decoded from registered state):
//   - x_gnt=1, bus_req=1, mux_sel per owner
//   - bus_we=mem_we captured at decision, else 0
//   - mux_sel and bus_we stable for the whole grant
//  Completion:
//   - bus_ack in GNT_x -> x_done=1 same cycle (combinational: state & bus_ack)
//   - next state IDLE; one bubble cycle before the next grant
//  Timeout:
//   - to_cnt clears on grant entry, increments each GNT cycle
//   - to_cnt==TIMEOUT-1 && !bus_ack -> arb_err=1 that cycle, next IDLE, no done
//   - ack on final cycle completes normally, no arb_err
//  Boundary cases:
//   - requester drops req mid-grant: ignored; transaction runs to ack/timeout; done still pulses
//   - bus_ack in IDLE: ignored; no done, no state change
//   - RST mid-grant: next cycle IDLE, outputs 0, no done/err; in-flight ack dropped
//   - if_done and mem_done are never both 1
//   - x_gnt implies bus_req
// STRUCTURE
//  Package otter_arb_pkg:
//   - typedef enum logic [1:0] arb_state_t {IDLE, GNT_IF, GNT_MEM}
//   - localparam MUX_SEL_IF = 1'b0, MUX_SEL_MEM = 1'b1
//  Sub-module arb_sat_counter #(MAX) (CLK, RST, clr, inc, cnt, at_max); instanced twice: starve_cnt, to_cnt.
// TESTING
//  1. if_req=1 @c1 -> @c2 if_gnt=1, mux_sel=0, bus_req=1, bus_we=0; bus_ack @c4 -> if_done=1 @c4, IDLE @c5.
//  2. if_req=mem_req=1, mem_we=1 @c1, starve_cnt=0 -> @c2 mem_gnt=1, mux_sel=1, bus_we=1; starve_cnt=1.
//  3. MAX_STARVE=2, both reqs held, ack 1 cycle after each grant -> grant order MEM, MEM, IF, MEM.
//  4. TIMEOUT=16, mem grant, no ack -> arb_err=1 on 16th grant cycle, mem_done never 1, IDLE next.
//  5. RST=1 during GNT_MEM, bus_ack next cycle -> all outputs 0, no mem_done, state IDLE.
//  6. bus_ack=1 in IDLE with no reqs -> no done, no grant, no err; state stays IDLE.

Source files
------------

// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package otter_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } arb_state_t;

  localparam logic MUX_SEL_IF  = 1'b0;
  localparam logic MUX_SEL_MEM = 1'b1;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
  parameter int unsigned MAX = 1,
  localparam int unsigned W  = $clog2(MAX + 1)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  assign at_max = (cnt == W'(MAX));

  // Count register: holds at MAX instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port memory bus between IF (0) and MEM (1).
// MEM wins contended decisions unless IF has already lost MAX_STARVE of them.
module mem_port_arbiter
  import otter_arb_pkg::*;
#(
  parameter int unsigned MAX_STARVE = 2,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic if_req,
  input  logic mem_req,
  input  logic mem_we,
  input  logic bus_ack,
  output logic if_gnt,
  output logic mem_gnt,
  output logic if_done,
  output logic mem_done,
  output logic mux_sel,
  output logic bus_req,
  output logic bus_we,
  output logic arb_err
);

  localparam int unsigned ST_W = $clog2(MAX_STARVE + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT);

  arb_state_t state, state_d;

  logic            starve_clr, starve_inc, starve_at_max, starve_win;
  logic            to_clr, to_inc, to_at_max, timeout;
  logic [ST_W-1:0] starve_cnt;
  logic [TO_W-1:0] to_cnt;

  // Counts contended decisions IF has lost since its last grant.
  arb_sat_counter #(.MAX(MAX_STARVE)) u_starve_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (starve_clr),
    .inc    (starve_inc),
    .cnt    (starve_cnt),
    .at_max (starve_at_max)
  );

  // Counts cycles spent in the current grant waiting for bus_ack.
  arb_sat_counter #(.MAX(TIMEOUT - 1)) u_to_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (to_clr),
    .inc    (to_inc),
    .cnt    (to_cnt),
    .at_max (to_at_max)
  );

  assign starve_win = (starve_cnt == ST_W'(MAX_STARVE));
  assign timeout    = (to_cnt == TO_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode, counter control and completion/abort pulses.
  always_comb begin
    state_d    = state;
    if_done    = 1'b0;
    mem_done   = 1'b0;
    arb_err    = 1'b0;
    starve_clr = 1'b0;
    starve_inc = 1'b0;
    to_clr     = 1'b0;
    to_inc     = 1'b0;
    case (state)
      IDLE: begin
        to_clr = 1'b1;
        if (if_req && !mem_req) begin
          state_d    = GNT_IF;
          starve_clr = 1'b1;
        end else if (mem_req && !if_req) begin
          state_d = GNT_MEM;
        end else if (if_req && mem_req) begin
          if (starve_win) begin
            state_d    = GNT_IF;
            starve_clr = 1'b1;
          end else begin
            state_d    = GNT_MEM;
            starve_inc = !starve_at_max;
          end
        end
      end
      GNT_IF: begin
        to_inc = !to_at_max;
        if (bus_ack) begin
          state_d = IDLE;
          if_done = !RST;
        end else if (timeout) begin
          state_d = IDLE;
          arb_err = !RST;
        end
      end
      GNT_MEM: begin
        to_inc = !to_at_max;
        if (bus_ack) begin
          state_d  = IDLE;
          mem_done = !RST;
        end else if (timeout) begin
          state_d = IDLE;
          arb_err = !RST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant-phase outputs; bus_we captures mem_we at the MEM decision and holds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      if_gnt  <= 1'b0;
      mem_gnt <= 1'b0;
      bus_req <= 1'b0;
      mux_sel <= MUX_SEL_IF;
      bus_we  <= 1'b0;
    end else begin
      if_gnt  <= (state_d == GNT_IF);
      mem_gnt <= (state_d == GNT_MEM);
      bus_req <= (state_d != IDLE);
      mux_sel <= (state_d == GNT_MEM) ? MUX_SEL_MEM : MUX_SEL_IF;
      bus_we  <= (state_d == GNT_MEM) && ((state == IDLE) ? mem_we : bus_we);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grant/done/err events are
// queued as stimulus is driven and matched as the arbiter produces them.
module tb_mem_port_arbiter;

  localparam int EV_NONE     = 0;
  localparam int EV_GNT_IF   = 1;
  localparam int EV_GNT_MEM  = 2;
  localparam int EV_DONE_IF  = 3;
  localparam int EV_DONE_MEM = 4;
  localparam int EV_ERR      = 5;

  typedef struct {
    int   kind;
    int   cyc;
    logic we;
  } ev_t;

  logic CLK = 1'b0;
  logic RST, if_req, mem_req, mem_we, bus_ack;
  logic if_gnt, mem_gnt, if_done, mem_done, mux_sel, bus_req, bus_we, arb_err;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic started = 1'b0;
  logic if_gnt_q = 1'b0;
  logic mem_gnt_q = 1'b0;
  ev_t  exp_q[$];

  mem_port_arbiter #(.MAX_STARVE(2), .TIMEOUT(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .if_req   (if_req),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .bus_ack  (bus_ack),
    .if_gnt   (if_gnt),
    .mem_gnt  (mem_gnt),
    .if_done  (if_done),
    .mem_done (mem_done),
    .mux_sel  (mux_sel),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .arb_err  (arb_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int at, input logic we);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.we   = we;
    exp_q.push_back(e);
  endtask

  task automatic obs_ev(input int kind, input logic we);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", 32'(kind), 32'(EV_NONE));
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_cycle", 32'(cyc), 32'(e.cyc));
      if (kind == EV_GNT_IF || kind == EV_GNT_MEM) chk("grant_bus_we", 32'(we), 32'(e.we));
    end
  endtask

  // Event monitor and bus invariants, sampled mid-cycle.
  always @(negedge CLK) begin
    if (started) begin
      if (if_gnt && !if_gnt_q)   obs_ev(EV_GNT_IF, bus_we);
      if (mem_gnt && !mem_gnt_q) obs_ev(EV_GNT_MEM, bus_we);
      if (if_done)               obs_ev(EV_DONE_IF, 1'b0);
      if (mem_done)              obs_ev(EV_DONE_MEM, 1'b0);
      if (arb_err)               obs_ev(EV_ERR, 1'b0);
      if (if_gnt || mem_gnt) begin
        chk("gnt_implies_bus_req", 32'(bus_req), 32'd1);
        chk("mux_sel_owner", 32'(mux_sel), 32'(mem_gnt));
      end
      if (if_gnt) chk("if_bus_we_zero", 32'(bus_we), 32'd0);
      chk("done_exclusive", 32'(if_done & mem_done), 32'd0);
      if_gnt_q  <= if_gnt;
      mem_gnt_q <= mem_gnt;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_if_gnt"},  32'(if_gnt),  32'd0);
    chk({tag, "_mem_gnt"}, 32'(mem_gnt), 32'd0);
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_mux_sel"}, 32'(mux_sel), 32'd0);
    chk({tag, "_bus_we"},  32'(bus_we),  32'd0);
    chk({tag, "_done"},    32'({if_done, mem_done}), 32'd0);
    chk({tag, "_err"},     32'(arb_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    RST = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; bus_ack = 1'b0;
    step();
    step();
    chk_idle("reset");
    RST = 1'b0;
    started = 1'b1;

    // IF-only request, ack on third grant cycle.
    step(); c = cyc;
    if_req = 1'b1;
    push_ev(EV_GNT_IF, c + 1, 1'b0);
    step();
    chk("t1_if_gnt", 32'(if_gnt), 32'd1);
    chk("t1_mux_sel", 32'(mux_sel), 32'd0);
    chk("t1_bus_req", 32'(bus_req), 32'd1);
    step();
    step(); bus_ack = 1'b1;
    push_ev(EV_DONE_IF, c + 3, 1'b0);
    step(); bus_ack = 1'b0; if_req = 1'b0;
    chk_idle("t1_bubble");

    // Contended decision: MEM write wins, IF follows.
    step(); c = cyc;
    if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b1;
    push_ev(EV_GNT_MEM, c + 1, 1'b1);
    step(); mem_we = 1'b0;
    chk("t2_mux_sel", 32'(mux_sel), 32'd1);
    step(); bus_ack = 1'b1;
    chk("t2_bus_we_held", 32'(bus_we), 32'd1);
    push_ev(EV_DONE_MEM, c + 2, 1'b0);
    step(); bus_ack = 1'b0; mem_req = 1'b0;
    push_ev(EV_GNT_IF, c + 4, 1'b0);
    step();
    step(); bus_ack = 1'b1;
    push_ev(EV_DONE_IF, c + 5, 1'b0);
    step(); bus_ack = 1'b0; if_req = 1'b0;

    // Starvation: both held, grant order MEM, MEM, IF, MEM.
    step(); c = cyc;
    if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
    push_ev(EV_GNT_MEM, c + 1,  1'b0); push_ev(EV_DONE_MEM, c + 2,  1'b0);
    push_ev(EV_GNT_MEM, c + 4,  1'b0); push_ev(EV_DONE_MEM, c + 5,  1'b0);
    push_ev(EV_GNT_IF,  c + 7,  1'b0); push_ev(EV_DONE_IF,  c + 8,  1'b0);
    push_ev(EV_GNT_MEM, c + 10, 1'b0); push_ev(EV_DONE_MEM, c + 11, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      step(); bus_ack = 1'b1;
      step(); bus_ack = 1'b0;
    end
    if_req = 1'b0; mem_req = 1'b0;

    // MEM grant never acked: abort on the 16th grant cycle.
    step(); c = cyc;
    mem_req = 1'b1;
    push_ev(EV_GNT_MEM, c + 1, 1'b0);
    push_ev(EV_ERR, c + 16, 1'b0);
    for (int i = 0; i < 16; i++) step();
    step(); mem_req = 1'b0;
    chk_idle("t4_after_err");

    // IF drops req mid-grant; ack on the final cycle still completes.
    step(); c = cyc;
    if_req = 1'b1;
    push_ev(EV_GNT_IF, c + 1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    if_req = 1'b0;
    for (int i = 0; i < 12; i++) step();
    bus_ack = 1'b1;
    push_ev(EV_DONE_IF, c + 16, 1'b0);
    step(); bus_ack = 1'b0;
    chk_idle("t7_after_done");

    // Reset mid-MEM-grant, then a stale ack.
    step(); c = cyc;
    mem_req = 1'b1; mem_we = 1'b1;
    push_ev(EV_GNT_MEM, c + 1, 1'b1);
    step();
    step(); RST = 1'b1;
    step(); RST = 1'b0; bus_ack = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    chk_idle("t5_post_rst");
    step(); bus_ack = 1'b0;
    chk_idle("t5_settled");

    // Ack in IDLE with no requests is ignored.
    step(); bus_ack = 1'b1;
    chk_idle("t6_ack_idle");
    step();
    chk_idle("t6_ack_idle2");
    step(); bus_ack = 1'b0;
    chk_idle("t6_end");

    repeat (3) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
